approx_adder_err_monitor: RTL and testbench
===========================================

Name: approx_adder_err_monitor

Overview:
Downstream characterisation stage for the approximate ripple-carry adders in the area/MSE study.
- Consumes each operand pair with the approximate adder's sum.
- Computes the exact sum internally and accumulates error metrics over a fixed-length run: squared-error sum, error count, maximum absolute error.
- Turns the combinational adder netlists into measurable MSE figures in simulation and on FPGA.

Parameters:
W, 8, operand width; approximate sum input is W+1 bits
NUM_SAMPLES, 65536, samples per run (default = exhaustive 2^(2W)); range 1..2^(2W)
ACC_W, 48, squared-error accumulator width; saturating

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: clear metrics and begin a run
in_valid  input  1  sample valid
in_ready  output  1  high while RUN and fewer than NUM_SAMPLES accepted
in_a  input  W  operand A
in_b  input  W  operand B
approx_sum  input  W+1  approximate adder result for in_a/in_b
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  run complete, results stable
sq_err_sum  output  ACC_W  sum of (approx-exact)^2
err_count  output  2W+1  samples with approx != exact
max_abs_err  output  W+1  maximum |approx-exact|
sample_count  output  2W+1  samples accepted this run
sat  output  1  sq_err_sum saturated at all-ones
err_sum  output  ACC_W  signed error sum (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM=IDLE, pipeline valids cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN.
  - RUN --last sample accepted--> DRAIN.
  - DRAIN --pipeline empty--> DONE.
  - DONE --start--> RUN.
- start in any state, including mid-RUN or DRAIN:
  - clears all accumulators, sample_count, sat and done;
  - flushes pipeline valids; enters RUN next cycle;
  - a sample presented in the start cycle is dropped.
- Handshake: a sample is accepted when in_valid && in_ready. in_ready is low outside RUN and is independent of in_valid. No backpressure inside the pipeline.
- Stage 1 (registered on accept):
  - exact = in_a + in_b, W+1 bits;
  - err = approx_sum - exact, signed W+2 bits;
  - abs_err = |err|, W+1 bits.
- Stage 2 (registered):
  - sq_err_sum += abs_err^2, saturating; sat sticky once saturated;
  - err_count += (err != 0);
  - max_abs_err = max(max_abs_err, abs_err).
- Latency: sample accepted at edge t is reflected in the metrics after edge t+2.
- sample_count increments on accept, so it leads the metrics by 2 cycles.
- Accepting sample NUM_SAMPLES drops in_ready in the same cycle (registered count compare) and moves to DRAIN. DONE follows 2 cycles later.
- busy = RUN|DRAIN. done = DONE. Outputs hold in DONE until start.
- Boundary cases:
  - abs_err up to 2^(W+1)-1 (e.g. exact=510, approx=0 -> 510);
  - NUM_SAMPLES=1 goes RUN->DRAIN after one accept;
  - counters never wrap, since NUM_SAMPLES <= 2^(2W) < 2^(2W+1).

Optional Feature:
Macro ERR_BIAS_EN.
- Defined: err_sum accumulates the signed err in stage 2 (two's complement, saturating at ±(2^(ACC_W-1)-1)) and is cleared by start and reset. Gives the mean-error bias.
- Undefined: no accumulator is built and err_sum is tied to 0.

Decomposition:
- Package approx_mon_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - width functions for err (W+2), count (2W+1);
  - ACC_W default constant.
- One sub-module: approx_err_calc (stage 1: exact sum, signed error, abs error, registered). The top holds the FSM and accumulators.

Test Plan:
- Exact-sum stimulus: start, feed all 65536 pairs with approx_sum=in_a+in_b -> done; sq_err_sum=0, err_count=0, max_abs_err=0, sample_count=65536, sat=0.
- NUM_SAMPLES=3; samples (3,5,approx 6), (10,1,approx 11), (200,100,approx 296) -> errors -2,0,-4; sq_err_sum=20, err_count=2, max_abs_err=4; err_sum=-6 with ERR_BIAS_EN.
- Extreme: (255,255,approx 0) -> abs_err=510, sq_err_sum=260100.
- in_valid toggling 1-0-1 with in_ready checked; after last accept in_ready=0 the same cycle; done asserts exactly 2 cycles after busy leaves RUN.
- start pulsed mid-run after 100 samples -> metrics and sample_count=0 next cycle, in_ready=1, fresh run completes normally.
- rst_n asserted mid-DRAIN -> all outputs 0 immediately (asynchronous); IDLE after release; in_ready=0 until start.

Source files
------------

// File: rtl/approx_mon_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_mon_pkg;

  localparam int ACC_W_DEF = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  // Signed error needs one extra bit over the W+1-bit sums.
  function automatic int err_width(input int w);
    return w + 2;
  endfunction

  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Stage 1: exact sum, signed error and absolute error of one accepted sample, registered.
module approx_err_calc
  import approx_mon_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           accept_i,
  input  logic [W-1:0]                   in_a_i,
  input  logic [W-1:0]                   in_b_i,
  input  logic [W:0]                     approx_sum_i,
  output logic                           valid_o,
  output logic signed [err_width(W)-1:0] err_o,
  output logic [W:0]                     abs_err_o
);

  localparam int EW = err_width(W);

  logic [W:0]           exact;
  logic signed [EW-1:0] err_d;
  logic [W:0]           abs_d;
  logic                 valid_q;
  logic signed [EW-1:0] err_q;
  logic [W:0]           abs_q;

  assign exact = {1'b0, in_a_i} + {1'b0, in_b_i};
  assign err_d = $signed({1'b0, approx_sum_i}) - $signed({1'b0, exact});
  // |err| never exceeds 2^(W+1)-1, so the sign bit can be dropped.
  assign abs_d = (W+1)'(err_d[EW-1] ? -err_d : err_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      err_q   <= '0;
      abs_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept_i;
      if (accept_i) begin
        err_q <= err_d;
        abs_q <= abs_d;
      end
    end
  end

  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign abs_err_o = abs_q;

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Error-metric accumulator for approximate adders: squared error, error count, max |error|.
// Optional signed error-sum accumulator built only when ERR_BIAS_EN is defined.
module approx_adder_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int W           = 8,
  parameter int NUM_SAMPLES = 65536,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic [W:0]        approx_sum,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sq_err_sum,
  output logic [2*W:0]      err_count,
  output logic [W:0]        max_abs_err,
  output logic [2*W:0]      sample_count,
  output logic              sat,
  output logic [ACC_W-1:0]  err_sum,
  output mon_state_e        dbg_state
);

  localparam int CW  = cnt_width(W);
  localparam int EW  = err_width(W);
  localparam int SQW = 2 * (W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);

  // Handshake: a sample transfers on a cycle with in_valid && in_ready and no start;
  // in_ready is a registered function of FSM state and count only, never of in_valid.
  logic       accept;
  mon_state_e state_q;
  logic       in_ready_q, busy_q, done_q;
  logic [CW-1:0] count_q;

  logic                 s1_valid;
  logic signed [EW-1:0] s1_err;
  logic [W:0]           s1_abs;

  logic             p_valid_q, p_nz_q;
  logic [SQW-1:0]   p_sq_q;
  logic [W:0]       p_abs_q;
  logic [ACC_W-1:0] sq_q, sq_d;
  logic [ACC_W:0]   sq_wide;
  logic             sat_q, sat_d;
  logic [CW-1:0]    cnt_q;
  logic [W:0]       max_q;

  assign accept = in_valid && in_ready_q && !start;

  approx_err_calc #(.W(W)) u_calc (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (start),
    .accept_i     (accept),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .approx_sum_i (approx_sum),
    .valid_o      (s1_valid),
    .err_o        (s1_err),
    .abs_err_o    (s1_abs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else if (start) begin
      state_q    <= ST_RUN;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            count_q <= count_q + CW'(1);
            if (count_q == LAST_IDX) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // Stage 1 empty means the last sample sits in the product register and
        // lands in the accumulators on this same edge.
        ST_DRAIN: begin
          if (!s1_valid) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sq_wide = {1'b0, sq_q} + {{(ACC_W+1-SQW){1'b0}}, p_sq_q};
  assign sat_d   = sat_q || (sq_wide >= {1'b0, {ACC_W{1'b1}}});
  assign sq_d    = sat_d ? {ACC_W{1'b1}} : sq_wide[ACC_W-1:0];

  // Stage 2 is split into a product register and the accumulate, giving the
  // two-edge accept-to-metrics latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_nz_q    <= 1'b0;
      p_sq_q    <= '0;
      p_abs_q   <= '0;
      sq_q      <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
      max_q     <= '0;
    end else if (start) begin
      p_valid_q <= 1'b0;
      sq_q      <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
      max_q     <= '0;
    end else begin
      p_valid_q <= s1_valid;
      if (s1_valid) begin
        p_sq_q  <= SQW'(s1_abs) * SQW'(s1_abs);
        p_nz_q  <= (s1_err != '0);
        p_abs_q <= s1_abs;
      end
      if (p_valid_q) begin
        sq_q  <= sq_d;
        sat_q <= sat_d;
        cnt_q <= cnt_q + {{(CW-1){1'b0}}, p_nz_q};
        if (p_abs_q > max_q) max_q <= p_abs_q;
      end
    end
  end

`ifdef ERR_BIAS_EN
  localparam logic signed [ACC_W:0] BIAS_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] BIAS_MIN = -BIAS_MAX;

  logic signed [EW-1:0]    p_err_q;
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic signed [ACC_W:0]   bias_wide;

  assign bias_wide = {bias_q[ACC_W-1], bias_q} + {{(ACC_W+1-EW){p_err_q[EW-1]}}, p_err_q};

  always_comb begin
    bias_d = bias_wide[ACC_W-1:0];
    if (bias_wide > BIAS_MAX)      bias_d = BIAS_MAX[ACC_W-1:0];
    else if (bias_wide < BIAS_MIN) bias_d = BIAS_MIN[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_err_q <= '0;
      bias_q  <= '0;
    end else if (start) begin
      bias_q <= '0;
    end else begin
      if (s1_valid) p_err_q <= s1_err;
      if (p_valid_q) bias_q <= bias_d;
    end
  end

  assign err_sum = bias_q;
`else
  assign err_sum = '0;
`endif

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = count_q;
  assign sq_err_sum   = sq_q;
  assign err_count    = cnt_q;
  assign max_abs_err  = max_q;
  assign sat          = sat_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor: a default (exhaustive) instance and a 3-sample instance.
// Expected err_sum follows ERR_BIAS_EN the same way as the design.
module tb_approx_adder_err_monitor;
  import approx_mon_pkg::*;

  localparam int W     = 8;
  localparam int ACC_W = 48;
  localparam int CW    = 17;

  typedef struct packed {
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [2:0][8:0] s;
    logic [47:0]     sq;
    logic [16:0]     cnt;
    logic [8:0]      mx;
    logic [47:0]     bias;
    logic            gaps;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic [W-1:0] in_a, in_b;
  logic [W:0]   approx_sum;

  logic b_rdy, b_busy, b_done, b_sat;
  logic [ACC_W-1:0] b_sq, b_es;
  logic [CW-1:0] b_cnt, b_sc;
  logic [W:0] b_max;
  mon_state_e b_st;

  logic s_rdy, s_busy, s_done, s_sat;
  logic [ACC_W-1:0] s_sq, s_es;
  logic [CW-1:0] s_cnt, s_sc;
  logic [W:0] s_max;
  mon_state_e s_st;

  int n_checks = 0;
  int n_pass   = 0;
  logic signed [9:0] exp_q[$];
  vec_t tbl[4];

  always #5 clk = ~clk;

  approx_adder_err_monitor dut_big (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_rdy),
    .in_a(in_a), .in_b(in_b), .approx_sum(approx_sum), .busy(b_busy), .done(b_done),
    .sq_err_sum(b_sq), .err_count(b_cnt), .max_abs_err(b_max), .sample_count(b_sc),
    .sat(b_sat), .err_sum(b_es), .dbg_state(b_st)
  );

  approx_adder_err_monitor #(.NUM_SAMPLES(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_rdy),
    .in_a(in_a), .in_b(in_b), .approx_sum(approx_sum), .busy(s_busy), .done(s_done),
    .sq_err_sum(s_sq), .err_count(s_cnt), .max_abs_err(s_max), .sample_count(s_sc),
    .sat(s_sat), .err_sum(s_es), .dbg_state(s_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [63:0] exp_bias(input longint b);
`ifdef ERR_BIAS_EN
    logic [47:0] t;
    t = 48'(b);
    return {16'd0, t};
`else
    return 64'(b) & 64'd0;
`endif
  endfunction

  // Reference: metrics of a 3-sample run straight from err = approx - (a + b).
  function automatic vec_t model_fill(input vec_t v_in);
    vec_t v;
    longint sq, bias;
    int cnt, mx, e, ae;
    v = v_in; sq = 0; bias = 0; cnt = 0; mx = 0;
    for (int i = 0; i < 3; i++) begin
      e  = int'(v.s[i]) - int'(v.a[i]) - int'(v.b[i]);
      ae = (e < 0) ? -e : e;
      sq += longint'(e * e);
      bias += longint'(e);
      if (e != 0) cnt++;
      if (ae > mx) mx = ae;
    end
    v.sq = 48'(sq); v.cnt = 17'(cnt); v.mx = 9'(mx); v.bias = 48'(bias);
    return v;
  endfunction

  task automatic check_zero(input string tag, input logic rdy, input logic busy, input logic done,
                            input logic sat, input logic [47:0] sq, input logic [47:0] es,
                            input logic [16:0] cnt, input logic [16:0] sc, input logic [8:0] mx);
    check({tag, "_ready"}, 64'(rdy), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_sat"},   64'(sat), 64'd0);
    check({tag, "_sq"},    64'(sq), 64'd0);
    check({tag, "_errsum"},64'(es), 64'd0);
    check({tag, "_errcnt"},64'(cnt), 64'd0);
    check({tag, "_count"}, 64'(sc), 64'd0);
    check({tag, "_max"},   64'(mx), 64'd0);
  endtask

  // One full run on the 3-sample instance; a junk sample rides along with start.
  task automatic run_small(input string tag, input vec_t v, input bit stop_in_drain);
    in_a = 8'd255; in_b = 8'd255; approx_sum = '0; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check({tag, "_start_ready"}, 64'(s_rdy), 64'd1);
    check({tag, "_start_count"}, 64'(s_sc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (v.gaps) begin
        in_valid = 1'b0;
        tick();
        check({tag, "_gap_ready"}, 64'(s_rdy), 64'd1);
        check({tag, "_gap_count"}, 64'(s_sc), 64'(i));
      end
      in_a = v.a[i]; in_b = v.b[i]; approx_sum = v.s[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_acc_count"}, 64'(s_sc), 64'(i + 1));
      check({tag, "_acc_ready"}, 64'(s_rdy), (i < 2) ? 64'd1 : 64'd0);
    end
    check({tag, "_drain_busy"}, 64'(s_busy), 64'd1);
    check({tag, "_drain_done"}, 64'(s_done), 64'd0);
    if (!stop_in_drain) begin
      tick();
      check({tag, "_t1_done"}, 64'(s_done), 64'd0);
      tick();
      check({tag, "_t2_done"}, 64'(s_done), 64'd1);
      check({tag, "_t2_busy"}, 64'(s_busy), 64'd0);
      check({tag, "_sq"},      64'(s_sq), 64'(v.sq));
      check({tag, "_errcnt"},  64'(s_cnt), 64'(v.cnt));
      check({tag, "_max"},     64'(s_max), 64'(v.mx));
      check({tag, "_sat"},     64'(s_sat), 64'd0);
      check({tag, "_errsum"},  64'(s_es), exp_bias(longint'($signed(v.bias))));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_hold_count"}, 64'(s_sc), 64'd3);
      check({tag, "_hold_done"},  64'(s_done), 64'd1);
    end
  endtask

  initial begin
    int acc, guard, e, ae, cnt, mx;
    longint sq, bias;

    tbl[0] = '0;
    tbl[0].a = {8'd200, 8'd10, 8'd3};  tbl[0].b = {8'd100, 8'd1, 8'd5};
    tbl[0].s = {9'd296, 9'd11, 9'd6};
    tbl[0].sq = 48'd20; tbl[0].cnt = 17'd2; tbl[0].mx = 9'd4; tbl[0].bias = -48'sd6; tbl[0].gaps = 1'b1;
    tbl[1] = '0;
    tbl[1].a = {8'd0, 8'd0, 8'd255};   tbl[1].b = {8'd0, 8'd0, 8'd255};
    tbl[1].s = {9'd0, 9'd0, 9'd0};
    tbl[1].sq = 48'd260100; tbl[1].cnt = 17'd1; tbl[1].mx = 9'd510; tbl[1].bias = -48'sd510; tbl[1].gaps = 1'b0;
    tbl[2] = '0;
    tbl[2].a = {8'd128, 8'd0, 8'd255}; tbl[2].b = {8'd128, 8'd0, 8'd255};
    tbl[2].s = {9'd0, 9'd511, 9'd511};
    tbl[2].sq = 48'd326658; tbl[2].cnt = 17'd3; tbl[2].mx = 9'd511; tbl[2].bias = 48'sd256; tbl[2].gaps = 1'b1;
    tbl[3] = '0;
    tbl[3].a = {8'd1, 8'd99, 8'd17};   tbl[3].b = {8'd254, 8'd0, 8'd34};
    tbl[3].s = {9'd255, 9'd99, 9'd51};
    tbl[3].gaps = 1'b0;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; approx_sum = '0;
    tick(); tick();
    check_zero("rst_big", b_rdy, b_busy, b_done, b_sat, b_sq, b_es, b_cnt, b_sc, b_max);
    check_zero("rst_small", s_rdy, s_busy, s_done, s_sat, s_sq, s_es, s_cnt, s_sc, s_max);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 64'(b_rdy), 64'd0);

    // Random partial run on the full-size instance, checked mid-RUN.
    start = 1'b1; tick(); start = 1'b0;
    check("big_start_ready", 64'(b_rdy), 64'd1);
    acc = 0; guard = 0;
    while (acc < 98 && guard < 2000) begin
      guard++;
      in_a = 8'($urandom_range(0, 255));
      in_b = 8'($urandom_range(0, 255));
      approx_sum = $urandom_range(0, 1) ? ({1'b0, in_a} + {1'b0, in_b}) : 9'($urandom_range(0, 511));
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        exp_q.push_back(10'(int'(approx_sum) - int'(in_a) - int'(in_b)));
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    sq = 0; bias = 0; cnt = 0; mx = 0;
    foreach (exp_q[k]) begin
      e = int'(exp_q[k]);
      ae = (e < 0) ? -e : e;
      sq += longint'(e * e);
      bias += longint'(e);
      if (e != 0) cnt++;
      if (ae > mx) mx = ae;
    end
    check("rand_big_count", 64'(b_sc), 64'(exp_q.size()));
    check("rand_big_sq", 64'(b_sq), 64'(sq));
    check("rand_big_errcnt", 64'(b_cnt), 64'(cnt));
    check("rand_big_max", 64'(b_max), 64'(mx));
    check("rand_big_errsum", 64'(b_es), exp_bias(bias));
    check("rand_big_ready", 64'(b_rdy), 64'd1);
    check("rand_big_done", 64'(b_done), 64'd0);

    // Two erroneous samples still in flight when start restarts the run.
    in_a = 8'd1; in_b = 8'd1; approx_sum = 9'd0; in_valid = 1'b1;
    tick(); tick();
    check("pre_restart_count", 64'(b_sc), 64'd100);
    in_a = 8'd255; in_b = 8'd255; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("restart_count", 64'(b_sc), 64'd0);
    check("restart_sq", 64'(b_sq), 64'd0);
    check("restart_max", 64'(b_max), 64'd0);
    check("restart_ready", 64'(b_rdy), 64'd1);
    tick(); tick();
    check("flush_sq", 64'(b_sq), 64'd0);
    check("flush_errcnt", 64'(b_cnt), 64'd0);
    check("flush_max", 64'(b_max), 64'd0);

    // Fresh run: every operand pair with an exact approximate sum.
    for (int i = 0; i < 65536; i++) begin
      in_a = 8'(i >> 8); in_b = 8'(i);
      approx_sum = {1'b0, in_a} + {1'b0, in_b};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("exh_ready_drop", 64'(b_rdy), 64'd0);
    check("exh_count", 64'(b_sc), 64'd65536);
    check("exh_drain_busy", 64'(b_busy), 64'd1);
    tick();
    check("exh_t1_done", 64'(b_done), 64'd0);
    tick();
    check("exh_done", 64'(b_done), 64'd1);
    check("exh_busy", 64'(b_busy), 64'd0);
    check("exh_sq", 64'(b_sq), 64'd0);
    check("exh_errcnt", 64'(b_cnt), 64'd0);
    check("exh_max", 64'(b_max), 64'd0);
    check("exh_sat", 64'(b_sat), 64'd0);
    check("exh_errsum", 64'(b_es), 64'd0);

    for (int t = 0; t < 4; t++) run_small($sformatf("tbl%0d", t), tbl[t], 1'b0);

    for (int r = 0; r < 30; r++) begin
      vec_t v;
      v = '0;
      for (int i = 0; i < 3; i++) begin
        v.a[i] = 8'($urandom_range(0, 255));
        v.b[i] = 8'($urandom_range(0, 255));
        v.s[i] = $urandom_range(0, 1) ? ({1'b0, v.a[i]} + {1'b0, v.b[i]}) : 9'($urandom_range(0, 511));
      end
      v.gaps = 1'($urandom_range(0, 1));
      run_small($sformatf("rand%0d", r), model_fill(v), 1'b0);
    end

    // Asynchronous reset while the small instance drains.
    run_small("rstdrain", tbl[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_small", s_rdy, s_busy, s_done, s_sat, s_sq, s_es, s_cnt, s_sc, s_max);
    check_zero("async_big", b_rdy, b_busy, b_done, b_sat, b_sq, b_es, b_cnt, b_sc, b_max);
    #2 rst_n = 1'b1;
    in_a = 8'd7; in_b = 8'd9; approx_sum = 9'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_ready", 64'(s_rdy), 64'd0);
      check("post_rst_busy", 64'(s_busy), 64'd0);
      check("post_rst_count", 64'(s_sc), 64'd0);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
